// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mod_mult_step.sv
// One iteration of interleaved modular multiplication: P2 = (2P + bit*a) mod n.
// Requires P < n and a < n so every intermediate fits in WIDTH+1 bits.
module mod_mult_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   p_o
);

  logic [WIDTH:0] n_ext;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] p1;
  logic [WIDTH:0] sum;

  always_comb begin
    n_ext = {1'b0, n_i};
    dbl   = p_i << 1;
    p1    = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    sum   = p1 + (bit_i ? {1'b0, a_i} : '0);
    p_o   = (sum >= n_ext) ? (sum - n_ext) : sum;
  end

endmodule

// File: rtl/mod_mult_seq.sv
// Sequential modular multiplier (a*b) mod n, scanning b MSB-first, one bit per cycle.
// Illegal operands (n==0 or a>=n) skip straight to DONE with err_o set.
module mod_mult_seq
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mm_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH:0]   p2;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             legal;

  assign legal = (n_i != '0) && (a_i < n_i);

  mod_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i   (p_q),
    .a_i   (a_q),
    .n_i   (n_q),
    .bit_i (b_q[cnt_q]),
    .p_o   (p2)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid_i) state_d = legal ? StRun : StDone;
      StRun:  if (cnt_q == '0) state_d = StDone;
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q == StRun);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            n_q   <= n_i;
            p_q   <= '0;
            cnt_q <= CntW'(WIDTH - 1);
            if (!legal) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        StRun: begin
          p_q <= p2;
          if (cnt_q == '0) begin
            result_q <= p2[WIDTH-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed bench for mod_mult_seq: an 8-bit instance for the hand vectors and a
// 32-bit instance for the wide boundary and randomised legal operations.
module tb_mod_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, n8 = '0;
  logic       in_ready8, out_valid8, err8, busy8;
  logic [7:0] result8;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, n32 = '0;
  logic        in_ready32, out_valid32, err32, busy32;
  logic [31:0] result32;

  int vectors = 0;
  int miscompares = 0;

  mod_mult_seq #(.WIDTH(8)) dut8 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid8),
    .in_ready_o  (in_ready8),
    .a_i         (a8),
    .b_i         (b8),
    .n_i         (n8),
    .out_valid_o (out_valid8),
    .out_ready_i (out_ready8),
    .result_o    (result8),
    .err_o       (err8),
    .busy_o      (busy8)
  );

  mod_mult_seq #(.WIDTH(32)) dut32 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid32),
    .in_ready_o  (in_ready32),
    .a_i         (a32),
    .b_i         (b32),
    .n_i         (n32),
    .out_valid_o (out_valid32),
    .out_ready_i (out_ready32),
    .result_o    (result32),
    .err_o       (err32),
    .busy_o      (busy32)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tn);
    int g;
    g = 0;
    while (!in_ready8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready8) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout got in_ready=%0b want 1", in_ready8);
    end
    in_valid8 = 1'b1;
    a8 = ta;
    b8 = tb;
    n8 = tn;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'hA5;
    b8 = 8'h5A;
    n8 = 8'h3C;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop8();
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0", in_ready8, out_valid8,
               busy8);
    end
    vectors++;
    if (result8 !== 8'd0 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data got result=%0d err=%b want 0 0", result8, err8);
    end
    vectors++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || result32 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_w32 got rdy=%b vld=%b result=%0d want 1 0 0", in_ready32,
               out_valid32, result32);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    start8(8'd7, 8'd9, 8'd11);
    vectors++;
    if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy8, in_ready8);
    end
    wait_valid8(lat);
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 8", lat);
    end
    vectors++;
    if (result8 !== 8'd8 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result got %0d err=%b want 8 err=0", result8, err8);
    end
    pop8();
    vectors++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || result8 !== 8'd8) begin
      miscompares++;
      $display("FAIL basic_after_pop got vld=%b rdy=%b result=%0d want 0 1 8", out_valid8,
               in_ready8, result8);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start8(8'd200, 8'd250, 8'd251);
    wait_valid8(lat);
    vectors++;
    if (result8 !== 8'd51) begin
      miscompares++;
      $display("FAIL bp_result got %0d want 51", result8);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (result8 !== 8'd51 || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall%0d got result=%0d vld=%b rdy=%b want 51 1 0", i, result8,
                 out_valid8, in_ready8);
      end
    end
    pop8();
  endtask

  task automatic test_error();
    int lat;
    logic [7:0] ea[2] = '{8'd5, 8'd12};
    logic [7:0] en[2] = '{8'd0, 8'd11};
    for (int i = 0; i < 2; i++) begin
      start8(ea[i], 8'd3, en[i]);
      vectors++;
      if (out_valid8 !== 1'b1 || err8 !== 1'b1 || result8 !== 8'd0 || busy8 !== 1'b0) begin
        miscompares++;
        $display("FAIL err_case%0d got vld=%b err=%b result=%0d busy=%b want 1 1 0 0", i,
                 out_valid8, err8, result8, busy8);
      end
      pop8();
      vectors++;
      if (err8 !== 1'b0 || out_valid8 !== 1'b0) begin
        miscompares++;
        $display("FAIL err_clear%0d got err=%b vld=%b want 0 0", i, err8, out_valid8);
      end
    end
    start8(8'd3, 8'd4, 8'd5);
    wait_valid8(lat);
    vectors++;
    if (result8 !== 8'd2 || err8 !== 1'b0 || lat != 8) begin
      miscompares++;
      $display("FAIL err_next_op got result=%0d err=%b lat=%0d want 2 0 8", result8, err8, lat);
    end
    pop8();
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit seen;
    start8(8'd7, 8'd9, 8'd11);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 ||
        result8 !== 8'd0 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset got rdy=%b vld=%b busy=%b result=%0d err=%b want 1 0 0 0 0",
               in_ready8, out_valid8, busy8, result8, err8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid8) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midrun_ghost got out_valid=1 want 0");
    end
    start8(8'd5, 8'd5, 8'd13);
    wait_valid8(lat);
    vectors++;
    if (result8 !== 8'd12 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_next got result=%0d err=%b want 12 0", result8, err8);
    end
    pop8();
  endtask

  task automatic test_boundaries();
    int lat;
    logic [7:0] ta[7] = '{8'd9, 8'd0,  8'd0,   8'd3,   8'd254, 8'd254, 8'd1};
    logic [7:0] tb[7] = '{8'd0, 8'd77, 8'd200, 8'd200, 8'd254, 8'd255, 8'd255};
    logic [7:0] tn[7] = '{8'd10, 8'd10, 8'd1,  8'd7,   8'd255, 8'd255, 8'd2};
    logic [7:0] te[7] = '{8'd0, 8'd0,  8'd0,   8'd5,   8'd1,   8'd0,   8'd1};
    for (int i = 0; i < 7; i++) begin
      start8(ta[i], tb[i], tn[i]);
      wait_valid8(lat);
      vectors++;
      if (result8 !== te[i] || err8 !== 1'b0 || out_valid8 !== 1'b1) begin
        miscompares++;
        $display("FAIL bound%0d %0d*%0d mod %0d got %0d err=%b want %0d", i, ta[i], tb[i],
                 tn[i], result8, err8, te[i]);
      end
      pop8();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[4] = '{8'd7,  8'd200, 8'd3, 8'd5};
    logic [7:0] vb[4] = '{8'd9,  8'd250, 8'd4, 8'd5};
    logic [7:0] vn[4] = '{8'd11, 8'd251, 8'd5, 8'd13};
    logic [7:0] ve[4] = '{8'd8,  8'd51,  8'd2, 8'd12};
    int ni, no, last;
    ni = 0;
    no = 0;
    last = -1;
    out_ready8 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid8) begin
        vectors++;
        if (no >= 4) begin
          miscompares++;
          $display("FAIL b2b_extra got result=%0d at cycle %0d want no result", result8, cyc);
        end else if (result8 !== ve[no] || err8 !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_result%0d got %0d want %0d", no, result8, ve[no]);
        end
        if (no > 0) begin
          vectors++;
          if (cyc - last != 10) begin
            miscompares++;
            $display("FAIL b2b_period%0d got %0d want 10", no, cyc - last);
          end
        end
        last = cyc;
        no++;
      end
      if (in_ready8) begin
        if (ni < 4) begin
          in_valid8 = 1'b1;
          a8 = va[ni];
          b8 = vb[ni];
          n8 = vn[ni];
          ni++;
        end else begin
          in_valid8 = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    vectors++;
    if (no != 4) begin
      miscompares++;
      $display("FAIL b2b_count got %0d results want 4", no);
    end
  endtask

  task automatic test_width32();
    logic [31:0] ta, tb, tn, te;
    longint unsigned prod;
    int g;
    bit done;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin tn = 32'hFFFF_FFFF; ta = tn - 1; tb = 32'hFFFF_FFFF; end
        1: begin tn = 32'h8000_0001; ta = tn - 1; tb = 32'hFFFF_FFFF; end
        2: begin tn = 32'hFFFF_FFFF; ta = 32'hFFFF_FFFD; tb = 32'h8000_0000; end
        default: begin
          tn = $urandom;
          if (tn == 0) tn = 1;
          ta = $urandom % tn;
          tb = $urandom;
        end
      endcase
      prod = 64'(ta) * 64'(tb);
      te = 32'(prod % 64'(tn));
      g = 0;
      while (!in_ready32 && g < 50) begin
        @(negedge clk);
        g++;
      end
      in_valid32 = 1'b1;
      a32 = ta;
      b32 = tb;
      n32 = tn;
      @(posedge clk);
      @(negedge clk);
      in_valid32 = 1'b0;
      a32 = $urandom;
      b32 = $urandom;
      n32 = $urandom;
      done = 1'b0;
      g = 0;
      while (!done && g < 200) begin
        out_ready32 = ($urandom_range(0, 3) != 0);
        if (out_valid32) begin
          vectors++;
          if (result32 !== te || err32 !== 1'b0) begin
            miscompares++;
            $display("FAIL w32_op%0d %0h*%0h mod %0h got %0h err=%b want %0h", i, ta, tb, tn,
                     result32, err32, te);
          end
          if (out_ready32) done = 1'b1;
        end
        @(negedge clk);
        g++;
      end
      out_ready32 = 1'b0;
      if (!done) begin
        vectors++;
        miscompares++;
        $display("FAIL w32_timeout%0d got no result want one", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_reset_midrun();
    test_boundaries();
    test_back_to_back();
    test_width32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
